uart_mmio_responder: RTL and testbench
======================================

// Module: uart_mmio_responder
// PURPOSE
//  Memory-mapped UART peripheral: the responder end of the CPU data-memory bus (MemRd/MemWr/addr/wdata/rdata).
//  It decodes three word registers in the peripheral window, serialises TX bytes and deserialises RX bytes (8N1).
//  It raises a level IRQ to the control unit. It sits beside DataMem/Peripheral and is driven from the EX/MEM stage signals.
// PARAMETERS
//  CLK_FREQ   50_000_000     core clock in Hz
//  BAUD       9600           line rate; DIV = CLK_FREQ/BAUD clocks per bit (integer divide, DIV >= 4)
//  BASE_ADDR  32'h40000018   address of TXD; RXD = BASE+4, CON = BASE+8
// PORTS
//  clk      in   1   core clock; all state updates on the rising edge
//  reset    in   1   synchronous, active-high
//  rd       in   1   bus read strobe (MEM stage)
//  wr       in   1   bus write strobe (MEM stage)
//  addr     in   32  byte address; only word-aligned matches decode
//  wdata    in   32  write data; TXD uses [7:0]
//  rdata    out  32  combinational read data; 32'h0 when no register is hit or rd=0
//  uart_rx  in   1   serial input, idle high, asynchronous
//  uart_tx  out  1   serial output, idle high
//  irq      out  1   level interrupt request
// BEHAVIOUR
//  Reset: uart_tx=1, irq=0, CON=0, rx_data=0, both FSMs IDLE, and the synchroniser flops are set to 1.
//  Registers:
//   TXD (W): when tx_busy=0, a write loads [7:0] and starts a frame. When tx_busy=1, the write is ignored.
//    A TXD read returns the last byte loaded, zero-extended.
//   RXD (R): returns {24'h0, rx_data}. A read clears rx_valid at the edge.
//   CON (R/W): [0] tx_ie, [1] rx_ie (both RW); [2] tx_done, [3] rx_valid, [4] tx_busy,
//    [5] overrun, [6] frame_err (all RO).
//    A CON read clears tx_done, overrun and frame_err at the edge. Writes affect only [1:0].
//  irq = (tx_ie & tx_done) | (rx_ie & rx_valid). It is registered, so it reflects the flags with 1 cycle of latency.
//  TX FSM: IDLE->START->DATA(8 bits, LSB first)->STOP->IDLE. Each state lasts DIV clocks.
//   uart_tx goes low on the edge after the accepting write. A frame is exactly 10*DIV clocks.
//   tx_busy is 1 from the accepting edge until the end of STOP. tx_done is set on the same edge tx_busy falls.
//  RX: uart_rx passes through a 2-FF synchroniser before the FSM, adding 2 cycles of latency.
//   RX FSM: IDLE->START->DATA->STOP.
//   IDLE: a falling edge of the synchronised input enters START.
//   START: at DIV/2 the line is resampled. If it is high, the event is a glitch: return to IDLE, set no flag.
//   DATA: 8 samples taken every DIV clocks at mid-bit, LSB first.
//   STOP: sampled after another DIV. If high, the byte is delivered. If low, frame_err=1, the byte is discarded,
//    and the FSM waits for the line to return high before entering IDLE.
//  Delivery: rx_data<=byte, rx_valid<=1. If rx_valid was already 1, overrun=1 and the new byte overwrites the old.
//  Simultaneous events:
//   RXD read on the same edge as a delivery: the delivery wins, rx_valid stays 1, no overrun.
//   CON read on the same edge as a flag set: the set wins.
//   rd and wr in the same cycle: both take effect.
//   Reset mid-frame: the frame is aborted, and uart_tx is 1 the cycle after reset is sampled.
//  Counters: bit timer is ceil(log2(DIV)) bits wide; bit index is 3 bits; no wrap beyond DIV-1.
// CONFIGURATION
//  UART_RX_FIFO_EN defined: a 4-entry RX FIFO replaces the single holding register.
//   rx_valid means the FIFO is not empty. An RXD read pops the head.
//   Delivery to a full FIFO drops the new byte and sets overrun. A pop and a push in the same cycle are both honoured.
//   CON[9:7] = occupancy.
//  UART_RX_FIFO_EN undefined: single register as above; CON[9:7] reads 0.
// TESTING (CLK_FREQ=160, BAUD=10 -> DIV=16)
//  1. After reset: uart_tx=1, irq=0, CON read = 0, RXD read = 0.
//  2. Write TXD=0x A5: uart_tx carries 0,1,0,1,0,0,1,0,1,1 with 16 clocks per bit.
//     tx_busy=1 for 160 clocks, then tx_done=1.
//     With tx_ie=1, irq rises one cycle later; a CON read drops it.
//  3. Drive RX frame 0x3C: 2+160 clocks after the start edge, rx_valid=1 and RXD reads 0x3C.
//     With rx_ie=1, irq=1; the next cycle after the RXD read, rx_valid=0.
//  4. Two RX frames (0x11, 0x22) with no read in between: RXD=0x22 and overrun=1.
//     With FIFO_EN: reads return 0x11 then 0x22, and overrun=0.
//  5. A 5-clock low glitch on uart_rx: no flag set. A frame with stop bit=0: frame_err=1 and rx_valid unchanged.
//  6. Write TXD=0x55 and, 20 clocks later, write TXD=0xFF: only 0x55 is sent.
//     Assert reset at clock 50: uart_tx=1 on the next cycle and the FSM returns to IDLE.

Source files
------------

// File: rtl/uart_mmio_responder_if.sv
// uart_mmio_responder_if: CPU data-memory bus between the MEM stage and the UART responder
interface uart_mmio_responder_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output rd, wr, addr, wdata, input rdata);
    modport slave (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_mmio_responder.sv
// uart_mmio_responder: memory-mapped 8N1 UART (TXD/RXD/CON) with level irq; UART_RX_FIFO_EN selects a 4-entry RX FIFO
module uart_mmio_responder #(
    parameter int          CLK_FREQ  = 50_000_000,
    parameter int          BAUD      = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_mmio_responder_if.slave        bus,
    input  logic                        uart_rx,
    output logic                        uart_tx,
    output logic                        irq
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int TW = $clog2(DIV);
    localparam logic [TW-1:0] LAST = TW'(DIV - 1);
    localparam logic [TW-1:0] HALF = TW'(DIV / 2 - 1);

    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;

    tx_state_t tx_st_q, tx_st_d;
    rx_state_t rx_st_q, rx_st_d;
    logic [TW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d, occ;
    logic [7:0] txd_q, txd_d, rx_sh_q, rx_sh_d, rx_head;
    logic uart_tx_q, uart_tx_d, tx_done_q, tx_done_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic tx_ie_q, rx_ie_q, irq_q, s1_q, s2_q;
    logic hit_txd, hit_rxd, hit_con, txd_wr, con_wr, con_rd, rxd_rd;
    logic tx_busy, tx_done_set, deliver, ferr_set, ovr_set, rx_valid;
    logic unused_wdata;

    assign hit_txd = bus.addr == BASE_ADDR;
    assign hit_rxd = bus.addr == BASE_ADDR + 32'd4;
    assign hit_con = bus.addr == BASE_ADDR + 32'd8;
    assign txd_wr = bus.wr && hit_txd;
    assign con_wr = bus.wr && hit_con;
    assign con_rd = bus.rd && hit_con;
    assign rxd_rd = bus.rd && hit_rxd;
    assign tx_busy = tx_st_q != T_IDLE;
    assign unused_wdata = ^bus.wdata[31:8];
    assign uart_tx = uart_tx_q;
    assign irq = irq_q;
    assign bus.rdata = !bus.rd ? 32'h0 : hit_txd ? {24'h0, txd_q} : hit_rxd ? {24'h0, rx_head} :
                       hit_con ? {22'h0, occ, frame_err_q, overrun_q, tx_busy, rx_valid, tx_done_q, rx_ie_q, tx_ie_q} : 32'h0;

    // TX frame sequencing; writes while busy fall through the IDLE-only accept
    always_comb begin
        tx_st_d = tx_st_q;
        tx_cnt_d = tx_cnt_q + TW'(1);
        tx_bit_d = tx_bit_q;
        txd_d = txd_q;
        tx_done_set = 1'b0;
        case (tx_st_q)
            T_IDLE: begin
                tx_cnt_d = '0;
                if (txd_wr) begin
                    tx_st_d = T_START;
                    txd_d = bus.wdata[7:0];
                end
            end
            T_START: if (tx_cnt_q == LAST) begin
                tx_st_d = T_DATA;
                tx_cnt_d = '0;
                tx_bit_d = '0;
            end
            T_DATA: if (tx_cnt_q == LAST) begin
                tx_cnt_d = '0;
                tx_bit_d = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_st_d = T_STOP;
            end
            default: if (tx_cnt_q == LAST) begin
                tx_st_d = T_IDLE;
                tx_cnt_d = '0;
                tx_done_set = 1'b1;
            end
        endcase
        uart_tx_d = tx_st_d == T_START ? 1'b0 : tx_st_d == T_DATA ? txd_d[tx_bit_d] : 1'b1;
        tx_done_d = tx_done_set || (tx_done_q && !con_rd);
    end

    // RX frame sampling; IDLE is only entered with the line high, so a low level there is a falling edge
    always_comb begin
        rx_st_d = rx_st_q;
        rx_cnt_d = rx_cnt_q + TW'(1);
        rx_bit_d = rx_bit_q;
        rx_sh_d = rx_sh_q;
        deliver = 1'b0;
        ferr_set = 1'b0;
        case (rx_st_q)
            R_IDLE: begin
                rx_cnt_d = '0;
                if (!s2_q) rx_st_d = R_START;
            end
            R_START: if (rx_cnt_q == HALF) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d = s2_q ? R_IDLE : R_DATA;
            end
            R_DATA: if (rx_cnt_q == LAST) begin
                rx_cnt_d = '0;
                rx_sh_d = {s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_st_d = R_STOP;
            end
            R_STOP: if (rx_cnt_q == LAST) begin
                rx_cnt_d = '0;
                deliver = s2_q;
                ferr_set = !s2_q;
                rx_st_d = s2_q ? R_IDLE : R_WAIT;
            end
            default: begin
                rx_cnt_d = '0;
                if (s2_q) rx_st_d = R_IDLE;
            end
        endcase
        overrun_d = ovr_set || (overrun_q && !con_rd);
        frame_err_d = ferr_set || (frame_err_q && !con_rd);
    end

    // Shared state: FSMs, synchroniser, flags, enables and registered irq
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_st_q <= T_IDLE;
            rx_st_q <= R_IDLE;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            tx_bit_q <= '0;
            rx_bit_q <= '0;
            txd_q <= '0;
            rx_sh_q <= '0;
            uart_tx_q <= 1'b1;
            tx_done_q <= 1'b0;
            overrun_q <= 1'b0;
            frame_err_q <= 1'b0;
            tx_ie_q <= 1'b0;
            rx_ie_q <= 1'b0;
            irq_q <= 1'b0;
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            tx_st_q <= tx_st_d;
            rx_st_q <= rx_st_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            tx_bit_q <= tx_bit_d;
            rx_bit_q <= rx_bit_d;
            txd_q <= txd_d;
            rx_sh_q <= rx_sh_d;
            uart_tx_q <= uart_tx_d;
            tx_done_q <= tx_done_d;
            overrun_q <= overrun_d;
            frame_err_q <= frame_err_d;
            tx_ie_q <= con_wr ? bus.wdata[0] : tx_ie_q;
            rx_ie_q <= con_wr ? bus.wdata[1] : rx_ie_q;
            irq_q <= (tx_ie_q && tx_done_q) || (rx_ie_q && rx_valid);
            s1_q <= uart_rx;
            s2_q <= s1_q;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic [7:0] fifo_q [4];
    logic [1:0] wp_q, rp_q;
    logic [2:0] occ_q;
    logic pop, push;
    assign pop = rxd_rd && occ_q != 3'd0;
    assign push = deliver && (occ_q != 3'd4 || pop);
    assign ovr_set = deliver && !push;
    assign rx_valid = occ_q != 3'd0;
    assign rx_head = fifo_q[rp_q];
    assign occ = occ_q;
    // RX FIFO: a full FIFO still accepts a push when a pop frees a slot on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
            occ_q <= '0;
        end else begin
            if (push) fifo_q[wp_q] <= rx_sh_q;
            wp_q <= push ? wp_q + 2'd1 : wp_q;
            rp_q <= pop ? rp_q + 2'd1 : rp_q;
            occ_q <= occ_q + 3'(push) - 3'(pop);
        end
    end
`else
    logic [7:0] rx_data_q;
    logic rx_valid_q;
    assign ovr_set = deliver && rx_valid_q && !rxd_rd;
    assign rx_valid = rx_valid_q;
    assign rx_head = rx_data_q;
    assign occ = 3'd0;
    // Single holding register: a delivery beats a same-edge RXD read
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_q <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_data_q <= deliver ? rx_sh_q : rx_data_q;
            rx_valid_q <= deliver || (rx_valid_q && !rxd_rd);
        end
    end
`endif
endmodule

// File: tb/tb_uart_mmio_responder.sv
// tb_uart_mmio_responder: directed vectors and serial sequences for uart_mmio_responder at DIV=16
module tb_uart_mmio_responder;
    localparam logic [31:0] TXD = 32'h40000018;
    localparam logic [31:0] RXD = 32'h4000001C;
    localparam logic [31:0] CON = 32'h40000020;
`ifdef UART_RX_FIFO_EN
    localparam logic [31:0] OCC1 = 32'h80;
`else
    localparam logic [31:0] OCC1 = 32'h0;
`endif

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx, irq;
    int checks = 0;
    int errors = 0;
    vec_t v[12];
    logic [31:0] d;
    logic [9:0] f, bad;

    uart_mmio_responder_if bif();

    uart_mmio_responder #(.CLK_FREQ(160), .BAUD(10), .BASE_ADDR(32'h40000018)) dut (
        .clk(clk), .reset(reset), .bus(bif), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] w);
        bif.wr = 1'b1;
        bif.addr = a;
        bif.wdata = w;
        tick(1);
        bif.wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] r);
        bif.rd = 1'b1;
        bif.addr = a;
        @(negedge clk);
        r = bif.rdata;
        tick(1);
        bif.rd = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            tick(16);
        end
        uart_rx = 1'b1;
    endtask

    initial begin
        bif.rd = 1'b0;
        bif.wr = 1'b0;
        bif.addr = '0;
        bif.wdata = '0;
        v[0]  = '{1'b1, 1'b0, CON, 32'h0, 32'h0};
        v[1]  = '{1'b1, 1'b0, RXD, 32'h0, 32'h0};
        v[2]  = '{1'b1, 1'b0, TXD, 32'h0, 32'h0};
        v[3]  = '{1'b1, 1'b0, CON + 32'd4, 32'h0, 32'h0};
        v[4]  = '{1'b1, 1'b0, CON + 32'd1, 32'h0, 32'h0};
        v[5]  = '{1'b0, 1'b1, CON, 32'h3, 32'h0};
        v[6]  = '{1'b1, 1'b0, CON, 32'h0, 32'h3};
        v[7]  = '{1'b1, 1'b1, CON, 32'h0, 32'h3};
        v[8]  = '{1'b1, 1'b0, CON, 32'h0, 32'h0};
        v[9]  = '{1'b0, 1'b1, CON, 32'hFFFF_FFFC, 32'h0};
        v[10] = '{1'b1, 1'b1, CON, 32'h1, 32'h0};
        v[11] = '{1'b1, 1'b0, CON, 32'h0, 32'h1};
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        check("reset uart_tx", {31'h0, uart_tx}, 32'h1);
        check("reset irq", {31'h0, irq}, 32'h0);
        tick(1);

        for (int i = 0; i < 12; i++) begin
            bif.rd = v[i].rd;
            bif.wr = v[i].wr;
            bif.addr = v[i].addr;
            bif.wdata = v[i].wdata;
            @(negedge clk);
            check($sformatf("vector %0d rdata", i), bif.rdata, v[i].exp);
            tick(1);
            bif.rd = 1'b0;
            bif.wr = 1'b0;
        end

        f = {1'b1, 8'hA5, 1'b0};
        bad = '0;
        wr_reg(TXD, 32'hA5);
        for (int i = 0; i < 160; i++) begin
            if (i == 0 || i == 159) begin
                bif.rd = 1'b1;
                bif.addr = CON;
            end
            @(negedge clk);
            if (uart_tx !== f[i / 16]) bad[i / 16] = 1'b1;
            if (i == 0 || i == 159) check($sformatf("tx_busy at %0d", i), {31'h0, bif.rdata[4]}, 32'h1);
            tick(1);
            bif.rd = 1'b0;
        end
        for (int b = 0; b < 10; b++) check($sformatf("tx A5 bit %0d", b), {31'h0, bad[b]}, 32'h0);
        @(negedge clk);
        check("tx idle after frame", {31'h0, uart_tx}, 32'h1);
        check("irq not yet after tx_done", {31'h0, irq}, 32'h0);
        tick(1);
        check("irq after tx_done", {31'h0, irq}, 32'h1);
        rd_reg(CON, d);
        check("CON tx_done", d, 32'h5);
        tick(1);
        check("irq cleared by CON read", {31'h0, irq}, 32'h0);
        rd_reg(TXD, d);
        check("TXD readback", d, 32'hA5);

        wr_reg(CON, 32'h2);
        send_frame(8'h3C, 1'b1);
        tick(2);
        check("irq rx", {31'h0, irq}, 32'h1);
        rd_reg(CON, d);
        check("CON rx_valid", d, 32'h0A | OCC1);
        rd_reg(RXD, d);
        check("RXD 3C", d, 32'h3C);
        rd_reg(CON, d);
        check("CON after RXD read", d, 32'h2);
        check("irq after RXD read", {31'h0, irq}, 32'h0);

        wr_reg(CON, 32'h0);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(2);
        rd_reg(CON, d);
`ifdef UART_RX_FIFO_EN
        check("CON two in FIFO", d, 32'h108);
        rd_reg(RXD, d);
        check("RXD first 11", d, 32'h11);
        rd_reg(RXD, d);
        check("RXD second 22", d, 32'h22);
`else
        check("CON overrun", d, 32'h28);
        rd_reg(RXD, d);
        check("RXD overwritten 22", d, 32'h22);
`endif
        rd_reg(CON, d);
        check("CON after drain", d, 32'h0);

        uart_rx = 1'b0;
        tick(5);
        uart_rx = 1'b1;
        tick(30);
        rd_reg(CON, d);
        check("CON after glitch", d, 32'h0);
        send_frame(8'h5A, 1'b0);
        tick(4);
        rd_reg(CON, d);
        check("CON frame_err", d, 32'h40);
        rd_reg(CON, d);
        check("CON frame_err cleared", d, 32'h0);
`ifndef UART_RX_FIFO_EN
        rd_reg(RXD, d);
        check("RXD kept after frame_err", d, 32'h22);
`endif

        wr_reg(TXD, 32'h55);
        tick(19);
        wr_reg(TXD, 32'hFF);
        rd_reg(TXD, d);
        check("TXD ignores busy write", d, 32'h55);
        tick(19);
        check("tx 55 data bit1 at clk 40", {31'h0, uart_tx}, 32'h0);
        tick(9);
        reset = 1'b1;
        tick(1);
        check("uart_tx after reset", {31'h0, uart_tx}, 32'h1);
        reset = 1'b0;
        rd_reg(CON, d);
        check("CON after mid-frame reset", d, 32'h0);
        tick(30);
        check("tx idle after reset", {31'h0, uart_tx}, 32'h1);
        check("irq after reset", {31'h0, irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
